fuzz_vector_harness: RTL and testbench
======================================

// Module: fuzz_vector_harness
// PURPOSE
//  Synthesizable stimulus player and response compactor for identity/equivalence fuzzing.
//  Replays a loaded table of input vectors onto a DUT's concatenated input bus, one vector per HOLD cycles.
//  Compresses the DUT output bus into a MISR signature and compares it with an expected signature.
//  Sits beside the DUT, so a whole run reduces to one pass/fail bit plus one signature word.
// PARAMETERS
//  IN_W   72          width of the concatenated DUT input bus
//  OUT_W  87          width of the DUT output bus (y)
//  DEPTH  21          number of vector slots
//  HOLD   1           clock cycles each vector is held (>=1)
//  POLY   87'h...21   MISR feedback polynomial, OUT_W bits; default in package
//  SEED   0           MISR initial value
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst        in   1                 synchronous, active-high reset
//  wr_en      in   1                 vector-table write strobe
//  wr_addr    in   $clog2(DEPTH)     vector slot to write
//  wr_data    in   IN_W              vector data
//  num_vec    in   $clog2(DEPTH+1)   vectors per run; sampled on start
//  exp_sig    in   OUT_W             expected final signature; sampled on start
//  start      in   1                 begin run (IDLE/DONE only)
//  abort      in   1                 cancel run
//  dut_y      in   OUT_W             DUT response
//  dut_in     out  IN_W              registered stimulus to DUT
//  busy       out  1                 high in APPLY
//  done       out  1                 high in DONE, until next start/abort/rst
//  pass       out  1                 signature==exp_sig; valid while done
//  signature  out  OUT_W             current MISR value
//  vec_idx    out  $clog2(DEPTH)     index of the vector on dut_in
// BEHAVIOUR
//  Reset: state=IDLE; dut_in=0, busy=0, done=0, pass=0, signature=SEED, vec_idx=0. Table contents are not reset.
//  FSM IDLE -> APPLY -> DONE. DONE -> APPLY on start. Any state -> IDLE on abort.
//  Priority: rst > abort > start.
//  Table write: accepted when wr_en=1 and state!=APPLY; ignored during APPLY. wr_addr>=DEPTH is ignored.
//  Start at cycle T (IDLE or DONE):
//   - latch n=min(num_vec,DEPTH) and exp_sig; signature<=SEED.
//   - n=0: DONE at T+1, dut_in=0, pass=(SEED==exp_sig).
//   - n>0: at T+1 state=APPLY, dut_in=mem[0], vec_idx=0, hold_cnt=0.
//  APPLY: hold_cnt counts 0..HOLD-1. In the cycle where hold_cnt==HOLD-1:
//   - MISR captures dut_y: sig <= {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? POLY : 0) ^ dut_y.
//   - if vec_idx<n-1: vec_idx++, dut_in<=mem[vec_idx+1], hold_cnt<=0.
//   - else: go to DONE, dut_in<=0.
//  Latency: DONE asserts at T+1+n*HOLD. pass is registered from the final signature in the same edge.
//  start during APPLY: ignored.
//  abort: next cycle state=IDLE, dut_in=0, signature=SEED, done=pass=0. A table write in the same cycle as abort is accepted.
//  DONE holds signature and pass stable.
//  The read of mem[idx] uses the table as it stood before any same-cycle write; writes only happen outside APPLY anyway.
// STRUCTURE
//  fuzz_harness_pkg: state enum {IDLE,APPLY,DONE}; DEFAULT_POLY; clog2 width helper constants.
//  Sub-module misr_reg #(W,POLY,SEED) with ports clk, rst, clr, en, d, q. The harness instantiates it once.
//  Vector table is a plain register array (DEPTH x IN_W) with a registered read into dut_in.
// TESTING
//  (Directed tests use IN_W=8, OUT_W=8, DEPTH=4, HOLD=1, POLY=8'h1D, SEED=0.)
//  T1 reset: rst high for 2 cycles -> dut_in=0, signature=0, busy/done/pass=0, vec_idx=0.
//  T2 basic run: load {11,22,33}, num_vec=3, dut_y follows 01,80,00, exp_sig=8'h19, start
//     -> dut_in 11/22/33 on cycles T+1..T+3; signature 01,82,19; done at T+4; pass=1.
//  T3 mismatch: repeat T2 with exp_sig=8'h18 -> done at T+4, pass=0, signature=19.
//  T4 HOLD=3, n=2: each vector held 3 cycles, exactly one capture per vector; done at T+7.
//  T5 edge cases:
//     num_vec=0 -> done at T+1, pass=(exp_sig==0);
//     num_vec=7 -> clamped to 4 vectors;
//     wr_en during APPLY -> table unchanged (check on the next run).
//  T6 abort/restart: abort at T+2 -> IDLE at T+3, dut_in=0, signature=0;
//     start together with abort -> abort wins; start from DONE -> clean rerun with identical signature.

Source files
------------

// File: rtl/fuzz_harness_pkg.sv
// fuzz_harness_pkg
//   Shared types and constants for the fuzz vector harness:
//   - state_e       : harness run state (IDLE, APPLY, DONE)
//   - DEFAULT_POLY  : default 87-bit MISR feedback polynomial
//   - idx_w()       : index width helper that never returns zero
//   - DEFAULT_*     : widths that go with the default 21-slot table
package fuzz_harness_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int          DEFAULT_OUT_W = 87;
  localparam logic [86:0] DEFAULT_POLY  = 87'h000000000000000000021;

  // Width of an index into n slots. A single slot still gets a 1-bit index,
  // so port and register declarations never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_DEPTH = 21;
  localparam int DEFAULT_IDX_W = idx_w(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DEPTH + 1);

endpackage

// File: rtl/misr_reg.sv
// misr_reg
//   Multiple-input signature register. On each enabled cycle the register
//   shifts left by one, folds the shifted-out MSB back in through POLY, and
//   XORs in the parallel input word.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset, loads SEED
//   i_clr  : synchronous clear, loads SEED (below reset, above enable)
//   i_en   : capture i_d into the signature this cycle
//   i_d    : parallel data word to compact
//   o_q    : current signature
module misr_reg
  import fuzz_harness_pkg::*;
#(
  parameter int           W    = DEFAULT_OUT_W,
  parameter logic [W-1:0] POLY = W'(DEFAULT_POLY),
  parameter logic [W-1:0] SEED = {W{1'b0}}
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sig;

  // One compaction step: shift, conditional polynomial feedback, data XOR.
  function automatic logic [W-1:0] misr_step(input logic [W-1:0] s,
                                             input logic [W-1:0] d);
    logic [W-1:0] fb;
    fb = s[W-1] ? POLY : {W{1'b0}};
    return {s[W-2:0], 1'b0} ^ fb ^ d;
  endfunction

  // Signature register: reset and clear both return to SEED.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sig <= SEED;
    end else if (i_clr) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= misr_step(r_sig, i_d);
    end else begin
      r_sig <= r_sig;
    end
  end

  assign o_q = r_sig;

endmodule

// File: rtl/fuzz_vector_harness.sv
// fuzz_vector_harness
//   Replays a loaded table of input vectors onto a DUT input bus, holding each
//   vector for HOLD cycles, and compacts the DUT response into a MISR
//   signature that is compared with an expected value at the end of a run.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_wr_en      : vector-table write strobe (ignored while applying)
//   i_wr_addr    : vector slot to write (out-of-range slots ignored)
//   i_wr_data    : vector data
//   i_num_vec    : vectors per run, clamped to DEPTH, sampled on start
//   i_exp_sig    : expected final signature, sampled on start
//   i_start      : begin a run from IDLE or DONE
//   i_abort      : cancel, return to IDLE (wins over start)
//   i_dut_y      : DUT response bus
//   o_dut_in     : registered stimulus to the DUT
//   o_busy       : high while vectors are being applied
//   o_done       : high once a run has finished, until start/abort/reset
//   o_pass       : final signature matched i_exp_sig; valid while o_done
//   o_signature  : current MISR value
//   o_vec_idx    : index of the vector currently on o_dut_in
module fuzz_vector_harness
  import fuzz_harness_pkg::*;
#(
  parameter int               IN_W  = 72,
  parameter int               OUT_W = DEFAULT_OUT_W,
  parameter int               DEPTH = DEFAULT_DEPTH,
  parameter int               HOLD  = 1,
  parameter logic [OUT_W-1:0] POLY  = OUT_W'(DEFAULT_POLY),
  parameter logic [OUT_W-1:0] SEED  = {OUT_W{1'b0}},
  localparam int              AW    = idx_w(DEPTH),
  localparam int              NW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [IN_W-1:0]  i_wr_data,
  input  logic [NW-1:0]    i_num_vec,
  input  logic [OUT_W-1:0] i_exp_sig,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [OUT_W-1:0] i_dut_y,
  output logic [IN_W-1:0]  o_dut_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [OUT_W-1:0] o_signature,
  output logic [AW-1:0]    o_vec_idx
);

  localparam int HW = idx_w(HOLD);

  state_e           r_state;
  logic [IN_W-1:0]  r_mem [DEPTH];
  logic [NW-1:0]    r_n;
  logic [OUT_W-1:0] r_exp;
  logic [AW-1:0]    r_idx;
  logic [HW-1:0]    r_hold;
  logic [IN_W-1:0]  r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [OUT_W-1:0] w_sig;
  logic [OUT_W-1:0] w_sig_next;
  logic [NW-1:0]    w_n_clamp;
  logic [AW-1:0]    w_idx_nxt;
  logic             w_wr_ok;
  logic             w_start_ok;
  logic             w_last_hold;
  logic             w_last_vec;
  logic             w_misr_clr;
  logic             w_misr_en;

  // Vector count clamped to the table size.
  always_comb begin
    w_n_clamp = i_num_vec;
    if (32'(i_num_vec) > DEPTH) begin
      w_n_clamp = NW'(DEPTH);
    end else begin
      w_n_clamp = i_num_vec;
    end
  end

  // Table write qualification. An abort leaves APPLY in the same edge, so a
  // write presented alongside it is taken.
  always_comb begin
    w_wr_ok = 1'b0;
    if (i_wr_en && ((r_state != APPLY) || i_abort) && (32'(i_wr_addr) < DEPTH)) begin
      w_wr_ok = 1'b1;
    end else begin
      w_wr_ok = 1'b0;
    end
  end

  assign w_start_ok  = i_start && (r_state != APPLY);
  assign w_last_hold = (r_state == APPLY) && (32'(r_hold) == (HOLD - 1));
  assign w_last_vec  = (32'(r_idx) + 32'd1) >= 32'(r_n);
  assign w_idx_nxt   = r_idx + AW'(1);

  // Signature after this cycle's capture; lets pass be registered on the
  // same edge that the final capture lands in the MISR.
  assign w_sig_next  = {w_sig[OUT_W-2:0], 1'b0}
                     ^ (w_sig[OUT_W-1] ? POLY : {OUT_W{1'b0}})
                     ^ i_dut_y;

  assign w_misr_clr  = i_abort || w_start_ok;
  assign w_misr_en   = w_last_hold && !i_abort;

  misr_reg #(
    .W    (OUT_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_misr_clr),
    .i_en  (w_misr_en),
    .i_d   (i_dut_y),
    .o_q   (w_sig)
  );

  // Vector table storage; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Run control FSM with registered stimulus and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_n      <= {NW{1'b0}};
      r_exp    <= {OUT_W{1'b0}};
      r_idx    <= {AW{1'b0}};
      r_hold   <= {HW{1'b0}};
      r_dut_in <= {IN_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (i_abort) begin
      r_state  <= IDLE;
      r_idx    <= {AW{1'b0}};
      r_hold   <= {HW{1'b0}};
      r_dut_in <= {IN_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_n    <= w_n_clamp;
            r_exp  <= i_exp_sig;
            r_idx  <= {AW{1'b0}};
            r_hold <= {HW{1'b0}};
            if (w_n_clamp == {NW{1'b0}}) begin
              // Empty run: the signature stays at SEED, so judge it directly.
              r_state  <= DONE;
              r_dut_in <= {IN_W{1'b0}};
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_pass   <= (SEED == i_exp_sig);
            end else begin
              r_state  <= APPLY;
              r_dut_in <= r_mem[{AW{1'b0}}];
              r_busy   <= 1'b1;
              r_done   <= 1'b0;
              r_pass   <= 1'b0;
            end
          end
        end
        APPLY: begin
          if (w_last_hold) begin
            if (!w_last_vec) begin
              r_idx    <= w_idx_nxt;
              r_dut_in <= r_mem[w_idx_nxt];
              r_hold   <= {HW{1'b0}};
            end else begin
              r_state  <= DONE;
              r_dut_in <= {IN_W{1'b0}};
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_pass   <= (w_sig_next == r_exp);
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_dut_in <= {IN_W{1'b0}};
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_pass   <= 1'b0;
        end
      endcase
    end
  end

  assign o_dut_in    = r_dut_in;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_signature = w_sig;
  assign o_vec_idx   = r_idx;

endmodule

// File: tb/tb_fuzz_vector_harness.sv
module tb_fuzz_vector_harness;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] num_vec;
  logic [7:0] exp_sig;
  logic       start_a;
  logic       start_b;
  logic       abort;
  logic [7:0] y_a, y_b;
  logic [7:0] din_a, din_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] sig_a, sig_b;
  logic [1:0] idx_a, idx_b;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the DUT under fuzz: fixed response per vector.
  function automatic logic [7:0] dut_model(input logic [7:0] x);
    case (x)
      8'h11:   return 8'h01;
      8'h22:   return 8'h80;
      8'h33:   return 8'h00;
      8'h44:   return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  assign y_a = dut_model(din_a);
  assign y_b = dut_model(din_b);

  fuzz_vector_harness #(
    .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(1), .POLY(8'h1D), .SEED(8'h00)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_num_vec(num_vec), .i_exp_sig(exp_sig),
    .i_start(start_a), .i_abort(abort), .i_dut_y(y_a),
    .o_dut_in(din_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_signature(sig_a), .o_vec_idx(idx_a)
  );

  fuzz_vector_harness #(
    .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(3), .POLY(8'h1D), .SEED(8'h00)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_num_vec(num_vec), .i_exp_sig(exp_sig),
    .i_start(start_b), .i_abort(abort), .i_dut_y(y_b),
    .o_dut_in(din_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_signature(sig_b), .o_vec_idx(idx_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    if (din_a !== 8'h00) begin n_mis++; $display("FAIL reset_din got %h want 00", din_a); end
    n_cmp++;
    if (sig_a !== 8'h00) begin n_mis++; $display("FAIL reset_sig got %h want 00", sig_a); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", busy_a); end
    n_cmp++;
    if (done_a !== 1'b0) begin n_mis++; $display("FAIL reset_done got %b want 0", done_a); end
    n_cmp++;
    if (pass_a !== 1'b0) begin n_mis++; $display("FAIL reset_pass got %b want 0", pass_a); end
    n_cmp++;
    if (idx_a !== 2'd0) begin n_mis++; $display("FAIL reset_idx got %0d want 0", idx_a); end
    n_cmp++;
    if (din_b !== 8'h00 || sig_b !== 8'h00 || done_b !== 1'b0 || busy_b !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_b got din=%h sig=%h done=%b busy=%b want 00/00/0/0",
               din_b, sig_b, done_b, busy_b);
    end
    n_cmp++;
  endtask

  task automatic load_table();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = vals[i];
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_basic_run();
    logic [7:0] e_din [3];
    logic [7:0] e_sig [3];
    e_din[0] = 8'h11; e_din[1] = 8'h22; e_din[2] = 8'h33;
    e_sig[0] = 8'h00; e_sig[1] = 8'h01; e_sig[2] = 8'h82;
    num_vec = 3'd3; exp_sig = 8'h19; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (din_a !== e_din[c]) begin n_mis++; $display("FAIL basic_din%0d got %h want %h", c, din_a, e_din[c]); end
      n_cmp++;
      if (sig_a !== e_sig[c]) begin n_mis++; $display("FAIL basic_sig%0d got %h want %h", c, sig_a, e_sig[c]); end
      n_cmp++;
      if (idx_a !== 2'(c)) begin n_mis++; $display("FAIL basic_idx%0d got %0d want %0d", c, idx_a, c); end
      n_cmp++;
      if (busy_a !== 1'b1 || done_a !== 1'b0) begin
        n_mis++; $display("FAIL basic_busy%0d got busy=%b done=%b want 1/0", c, busy_a, done_a);
      end
      n_cmp++;
      // A start pulse in the middle of APPLY must change nothing.
      start_a = (c == 1);
      step();
      start_a = 1'b0;
    end
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      n_mis++; $display("FAIL basic_done got done=%b busy=%b want 1/0", done_a, busy_a);
    end
    n_cmp++;
    if (sig_a !== 8'h19) begin n_mis++; $display("FAIL basic_final_sig got %h want 19", sig_a); end
    n_cmp++;
    if (pass_a !== 1'b1) begin n_mis++; $display("FAIL basic_pass got %b want 1", pass_a); end
    n_cmp++;
    if (din_a !== 8'h00) begin n_mis++; $display("FAIL basic_din_done got %h want 00", din_a); end
    n_cmp++;
  endtask

  task automatic test_mismatch();
    num_vec = 3'd3; exp_sig = 8'h18; start_a = 1'b1;
    step();
    start_a = 1'b0;
    if (done_a !== 1'b0) begin n_mis++; $display("FAIL mism_done_cleared got %b want 0", done_a); end
    n_cmp++;
    step();
    step();
    if (done_a !== 1'b0) begin n_mis++; $display("FAIL mism_done_early got %b want 0", done_a); end
    n_cmp++;
    step();
    if (done_a !== 1'b1) begin n_mis++; $display("FAIL mism_done got %b want 1", done_a); end
    n_cmp++;
    if (pass_a !== 1'b0) begin n_mis++; $display("FAIL mism_pass got %b want 0", pass_a); end
    n_cmp++;
    if (sig_a !== 8'h19) begin n_mis++; $display("FAIL mism_sig got %h want 19", sig_a); end
    n_cmp++;
    step();
    if (sig_a !== 8'h19 || done_a !== 1'b1 || pass_a !== 1'b0) begin
      n_mis++; $display("FAIL mism_hold got sig=%h done=%b pass=%b want 19/1/0", sig_a, done_a, pass_a);
    end
    n_cmp++;
  endtask

  task automatic test_hold();
    logic [7:0] e_din, e_sig;
    num_vec = 3'd2; exp_sig = 8'h82; start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 0; c < 6; c++) begin
      e_din = (c < 3) ? 8'h11 : 8'h22;
      e_sig = (c < 3) ? 8'h00 : 8'h01;
      if (din_b !== e_din) begin n_mis++; $display("FAIL hold_din%0d got %h want %h", c, din_b, e_din); end
      n_cmp++;
      if (sig_b !== e_sig) begin n_mis++; $display("FAIL hold_sig%0d got %h want %h", c, sig_b, e_sig); end
      n_cmp++;
      if (done_b !== 1'b0) begin n_mis++; $display("FAIL hold_done%0d got %b want 0", c, done_b); end
      n_cmp++;
      step();
    end
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      n_mis++; $display("FAIL hold_done got done=%b busy=%b want 1/0", done_b, busy_b);
    end
    n_cmp++;
    if (sig_b !== 8'h82) begin n_mis++; $display("FAIL hold_final_sig got %h want 82", sig_b); end
    n_cmp++;
    if (pass_b !== 1'b1) begin n_mis++; $display("FAIL hold_pass got %b want 1", pass_b); end
    n_cmp++;
  endtask

  task automatic test_edge_cases();
    logic [7:0] e_din [4];
    e_din[0] = 8'h11; e_din[1] = 8'h22; e_din[2] = 8'h33; e_din[3] = 8'h44;
    // Zero vectors, expected matches SEED.
    num_vec = 3'd0; exp_sig = 8'h00; start_a = 1'b1;
    step();
    start_a = 1'b0;
    if (done_a !== 1'b1 || pass_a !== 1'b1 || busy_a !== 1'b0) begin
      n_mis++; $display("FAIL zero_match got done=%b pass=%b busy=%b want 1/1/0", done_a, pass_a, busy_a);
    end
    n_cmp++;
    if (sig_a !== 8'h00 || din_a !== 8'h00) begin
      n_mis++; $display("FAIL zero_sig got sig=%h din=%h want 00/00", sig_a, din_a);
    end
    n_cmp++;
    // Zero vectors, expected differs from SEED.
    exp_sig = 8'h05; start_a = 1'b1;
    step();
    start_a = 1'b0;
    if (done_a !== 1'b1 || pass_a !== 1'b0) begin
      n_mis++; $display("FAIL zero_mismatch got done=%b pass=%b want 1/0", done_a, pass_a);
    end
    n_cmp++;
    // Seven requested, clamped to all four slots: sig 01,82,19,36.
    num_vec = 3'd7; exp_sig = 8'h36; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (din_a !== e_din[c] || idx_a !== 2'(c) || done_a !== 1'b0) begin
        n_mis++; $display("FAIL clamp_cyc%0d got din=%h idx=%0d done=%b want %h/%0d/0",
                          c, din_a, idx_a, done_a, e_din[c], c);
      end
      n_cmp++;
      step();
    end
    if (done_a !== 1'b1 || sig_a !== 8'h36 || pass_a !== 1'b1) begin
      n_mis++; $display("FAIL clamp_done got done=%b sig=%h pass=%b want 1/36/1", done_a, sig_a, pass_a);
    end
    n_cmp++;
    // Write presented during APPLY must be dropped.
    num_vec = 3'd1; exp_sig = 8'h01; start_a = 1'b1;
    step();
    start_a = 1'b0;
    if (busy_a !== 1'b1) begin n_mis++; $display("FAIL wr_apply_busy got %b want 1", busy_a); end
    n_cmp++;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    if (done_a !== 1'b1 || sig_a !== 8'h01) begin
      n_mis++; $display("FAIL wr_apply_run got done=%b sig=%h want 1/01", done_a, sig_a);
    end
    n_cmp++;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    if (din_a !== 8'h11) begin n_mis++; $display("FAIL wr_apply_table got %h want 11", din_a); end
    n_cmp++;
    step();
    if (done_a !== 1'b1 || pass_a !== 1'b1 || sig_a !== 8'h01) begin
      n_mis++; $display("FAIL wr_apply_rerun got done=%b pass=%b sig=%h want 1/1/01", done_a, pass_a, sig_a);
    end
    n_cmp++;
  endtask

  task automatic test_abort_restart();
    num_vec = 3'd3; exp_sig = 8'h19; start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    if (din_a !== 8'h22 || sig_a !== 8'h01) begin
      n_mis++; $display("FAIL abort_pre got din=%h sig=%h want 22/01", din_a, sig_a);
    end
    n_cmp++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
      n_mis++; $display("FAIL abort_state got busy=%b done=%b pass=%b want 0/0/0", busy_a, done_a, pass_a);
    end
    n_cmp++;
    if (din_a !== 8'h00 || sig_a !== 8'h00 || idx_a !== 2'd0) begin
      n_mis++; $display("FAIL abort_clear got din=%h sig=%h idx=%0d want 00/00/0", din_a, sig_a, idx_a);
    end
    n_cmp++;
    step();
    if (sig_a !== 8'h00 || busy_a !== 1'b0) begin
      n_mis++; $display("FAIL abort_idle got sig=%h busy=%b want 00/0", sig_a, busy_a);
    end
    n_cmp++;
    // Start and abort together: abort wins, no run begins.
    start_a = 1'b1; abort = 1'b1;
    step();
    start_a = 1'b0; abort = 1'b0;
    if (busy_a !== 1'b0 || din_a !== 8'h00 || done_a !== 1'b0) begin
      n_mis++; $display("FAIL abort_wins got busy=%b din=%h done=%b want 0/00/0", busy_a, din_a, done_a);
    end
    n_cmp++;
    step();
    if (busy_a !== 1'b0) begin n_mis++; $display("FAIL abort_wins_late got %b want 0", busy_a); end
    n_cmp++;
    // Fresh run from IDLE, then a rerun from DONE must reproduce it.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step(); step();
    if (done_a !== 1'b1 || pass_a !== 1'b1 || sig_a !== 8'h19) begin
      n_mis++; $display("FAIL restart_run got done=%b pass=%b sig=%h want 1/1/19", done_a, pass_a, sig_a);
    end
    n_cmp++;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    if (done_a !== 1'b0 || busy_a !== 1'b1 || din_a !== 8'h11 || sig_a !== 8'h00) begin
      n_mis++; $display("FAIL rerun_start got done=%b busy=%b din=%h sig=%h want 0/1/11/00",
                        done_a, busy_a, din_a, sig_a);
    end
    n_cmp++;
    step(); step(); step();
    if (done_a !== 1'b1 || pass_a !== 1'b1 || sig_a !== 8'h19) begin
      n_mis++; $display("FAIL rerun_done got done=%b pass=%b sig=%h want 1/1/19", done_a, pass_a, sig_a);
    end
    n_cmp++;
    // Abort out of DONE clears status and signature.
    abort = 1'b1;
    step();
    abort = 1'b0;
    if (done_a !== 1'b0 || pass_a !== 1'b0 || sig_a !== 8'h00) begin
      n_mis++; $display("FAIL abort_done got done=%b pass=%b sig=%h want 0/0/00", done_a, pass_a, sig_a);
    end
    n_cmp++;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    num_vec = 3'd0; exp_sig = 8'h00; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    test_reset();
    load_table();
    test_basic_run();
    test_mismatch();
    test_hold();
    test_edge_cases();
    test_abort_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
